// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : DEPTH-stage valid/ready register pipeline with a
//               combinational ready chain (no skid buffer), per-stage
//               flush, hazard-bubble insertion and a registered occupancy
//               count.
//
// Ports       : clk           - rising-edge clock
//               reset_b       - asynchronous active-low reset
//               in_valid      - upstream payload valid
//               in_data       - upstream payload [WIDTH]
//               in_ready      - stage 0 accepts this cycle
//               insert_bubble - inject an invalid entry into stage 0
//               flush         - per-stage kill [DEPTH]
//               out_valid     - valid bit of stage DEPTH-1
//               out_data      - payload of stage DEPTH-1 [WIDTH]
//               out_ready     - downstream consumer accepts
//               occupancy     - number of valid stages (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    input  logic                           insert_bubble,
    input  logic [DEPTH-1:0]               flush,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int c_occ_w = $clog2(DEPTH + 1);

    // Stage registers
    logic [DEPTH-1:0]   r_valid;
    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [c_occ_w-1:0] r_occupancy;

    // Combinational next-state
    logic [DEPTH-1:0]   w_adv;
    logic               w_adv_carry;
    logic [DEPTH-1:0]   w_valid_nxt;
    logic [WIDTH-1:0]   w_data_nxt [DEPTH];
    logic               w_src_valid;
    logic [WIDTH-1:0]   w_src_data;
    logic [c_occ_w-1:0] w_occ_nxt;

    // Ready chain, walked from the output side back to stage 0. A stage
    // advances if it is empty or the stage after it advances. Flush does not
    // enter this chain: a stage feeding a flushed stage still counts as
    // having handed its item over.
    always_comb begin
        w_adv       = '0;
        w_adv_carry = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i]    = w_adv_carry | ~r_valid[i];
            w_adv_carry = w_adv[i];
        end
    end

    // Next-state, walked from stage 0 upward. w_src_* carries the contents
    // of the stage below (or the upstream port for stage 0). Invalid
    // entries always carry zero data so bubbles behave as NOPs.
    always_comb begin
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_src_valid = in_valid & ~insert_bubble;
        w_src_data  = in_data;
        w_occ_nxt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i]) begin
                w_valid_nxt[i] = 1'b0;
                w_data_nxt[i]  = '0;
            end else if (w_adv[i]) begin
                w_valid_nxt[i] = w_src_valid;
                w_data_nxt[i]  = w_src_valid ? w_src_data : '0;
            end
            w_src_valid = r_valid[i];
            w_src_data  = r_data[i];
            w_occ_nxt   = w_occ_nxt + c_occ_w'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_valid     <= '0;
            r_occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid     <= w_valid_nxt;
            r_occupancy <= w_occ_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
        end
    end

    assign in_ready  = w_adv[0] & ~insert_bubble;
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign occupancy = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg_chain
// Description : Directed self-checking bench for pipe_reg_chain. A default
//               (WIDTH=64, DEPTH=4) instance covers streaming, back-pressure,
//               flush, bubble and async reset; a DEPTH=1 instance covers
//               the single-stage output-flush case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;

    logic        clk;
    logic        reset_b;

    // Default instance
    logic        in_valid, in_ready, insert_bubble, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [3:0]  flush;
    logic [2:0]  occupancy;

    // DEPTH=1 instance
    logic        in_valid1, in_ready1, insert_bubble1, out_valid1, out_ready1;
    logic [7:0]  in_data1, out_data1;
    logic [0:0]  flush1;
    logic [0:0]  occupancy1;

    int n_cmp;
    int n_err;

    pipe_reg_chain dut (
        .clk(clk), .reset_b(reset_b),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .insert_bubble(insert_bubble), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .reset_b(reset_b),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .insert_bubble(insert_bubble1), .flush(flush1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .occupancy(occupancy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; insert_bubble = 1'b0; flush = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; insert_bubble1 = 1'b0;
        flush1 = '0; out_ready1 = 1'b1;
        reset_b = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        step(); step();
        reset_b = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    // Stream 1..8 with out_ready=1, then drain.
    task automatic test_stream();
        logic        exp_v;
        logic [63:0] exp_d;
        int          exp_o;
        idle_inputs();
        out_ready = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            in_valid = (n <= 8);
            in_data  = (n <= 8) ? 64'(n) : 64'h0;
            step();
            exp_v = (n >= 4 && n <= 11);
            exp_d = exp_v ? 64'(n - 3) : 64'h0;
            exp_o = (n <= 8) ? ((n < 4) ? n : 4) : 12 - n;
            n_cmp++; if (out_valid !== exp_v || out_data !== exp_d) begin
                n_err++; $display("FAIL stream_out edge %0d got v=%b d=%h want v=%b d=%h", n, out_valid, out_data, exp_v, exp_d);
            end
            n_cmp++; if (occupancy !== 3'(exp_o)) begin
                n_err++; $display("FAIL stream_occ edge %0d got %0d want %0d", n, occupancy, exp_o);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_seq [4];
        exp_seq[0] = 64'hB; exp_seq[1] = 64'hC; exp_seq[2] = 64'hD; exp_seq[3] = 64'h0;
        idle_inputs();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 64'(10 + k);
            step();
        end
        in_valid = 1'b1; in_data = 64'hE;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        step(); step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hA) begin
            n_err++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=a", out_valid, out_data);
        end
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_occ got %0d want 4", occupancy); end
        in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (out_data !== exp_seq[k] || out_valid !== (k < 3)) begin
                n_err++; $display("FAIL bp_drain %0d got v=%b d=%h want d=%h", k, out_valid, out_data, exp_seq[k]);
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] got [$];
        idle_inputs();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = 64'(k);
            step();
        end
        in_valid = 1'b0; in_data = '0;
        flush = 4'b0110;
        step();
        flush = '0;
        n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL flush_occ got %0d want 2", occupancy); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h1) begin
            n_err++; $display("FAIL flush_out_hold got v=%b d=%h want v=1 d=1", out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) got.push_back(out_data);
            step();
            if (k == 0) begin
                n_cmp++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin
                    n_err++; $display("FAIL flush_zero got v=%b d=%h want v=0 d=0", out_valid, out_data);
                end
            end
        end
        n_cmp++; if (got.size() !== 2 || got[0] !== 64'h1 || got[1] !== 64'h4) begin
            n_err++; $display("FAIL flush_seq got %0d items first=%h want 2 items 1,4", got.size(), (got.size() > 0) ? got[0] : 64'hx);
        end
    endtask

    task automatic test_bubble();
        logic        ev [8];
        logic [63:0] ed [8];
        for (int k = 0; k < 8; k++) begin ev[k] = 1'b0; ed[k] = 64'h0; end
        ev[3] = 1'b1; ed[3] = 64'h5;
        ev[5] = 1'b1; ed[5] = 64'h6;
        ev[6] = 1'b1; ed[6] = 64'h7;
        idle_inputs();
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            case (n)
                0: begin in_valid = 1'b1; in_data = 64'h5; end
                1: begin in_valid = 1'b1; in_data = 64'h6; insert_bubble = 1'b1; end
                2: begin in_valid = 1'b1; in_data = 64'h6; insert_bubble = 1'b0; end
                3: begin in_valid = 1'b1; in_data = 64'h7; end
                default: begin in_valid = 1'b0; in_data = '0; end
            endcase
            if (n == 1) begin
                #1;
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bubble_in_ready got %b want 0", in_ready); end
            end
            step();
            n_cmp++; if (out_valid !== ev[n] || out_data !== ed[n]) begin
                n_err++; $display("FAIL bubble_out edge %0d got v=%b d=%h want v=%b d=%h", n + 1, out_valid, out_data, ev[n], ed[n]);
            end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = 64'(32 + k);
            step();
        end
        in_valid = 1'b0; in_data = '0;
        step();
        n_cmp++; if (occupancy !== 3'd3 || out_valid !== 1'b1 || out_data !== 64'h21) begin
            n_err++; $display("FAIL arst_pre got occ=%0d v=%b d=%h want occ=3 v=1 d=21", occupancy, out_valid, out_data);
        end
        #2;
        reset_b = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_data !== 64'h0) begin
            n_err++; $display("FAIL arst_immediate got occ=%0d v=%b d=%h want 0 0 0", occupancy, out_valid, out_data);
        end
        #1;
        reset_b = 1'b1;
        out_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            in_valid = (n == 1); in_data = (n == 1) ? 64'h55 : 64'h0;
            step();
            n_cmp++; if (out_valid !== (n == 4) || out_data !== ((n == 4) ? 64'h55 : 64'h0)) begin
                n_err++; $display("FAIL arst_latency edge %0d got v=%b d=%h", n, out_valid, out_data);
            end
        end
    endtask

    task automatic test_depth1();
        int xfers;
        xfers = 0;
        out_ready1 = 1'b1; in_valid1 = 1'b1; in_data1 = 8'h3C; flush1 = 1'b0;
        step();
        n_cmp++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h3C || occupancy1 !== 1'b1) begin
            n_err++; $display("FAIL d1_load got v=%b d=%h occ=%0d want 1 3c 1", out_valid1, out_data1, occupancy1);
        end
        in_valid1 = 1'b0; in_data1 = '0; flush1 = 1'b1;
        #1;
        n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL d1_in_ready got %b want 1", in_ready1); end
        if (out_valid1 && out_ready1) xfers++;
        step();
        flush1 = 1'b0;
        n_cmp++; if (xfers !== 1) begin n_err++; $display("FAIL d1_xfer got %0d want 1", xfers); end
        n_cmp++; if (out_valid1 !== 1'b0 || out_data1 !== 8'h0 || occupancy1 !== 1'b0) begin
            n_err++; $display("FAIL d1_empty got v=%b d=%h occ=%0d want 0 0 0", out_valid1, out_data1, occupancy1);
        end
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 8'h81;
        step();
        in_data1 = 8'h99;
        #1;
        n_cmp++; if (in_ready1 !== 1'b0 || out_data1 !== 8'h81) begin
            n_err++; $display("FAIL d1_stall got rdy=%b d=%h want 0 81", in_ready1, out_data1);
        end
        in_valid1 = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_async_reset();
        test_depth1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
